// File: rtl/cpu_regfile_mp_if.sv
// Register file port bundle: read ports, write ports,
// issue/flush scoreboard controls and debug read.
interface cpu_regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1
);
    logic [NREAD*5-1:0]     rs_addr;
    logic [NREAD*XLEN-1:0]  rs_data;
    logic [NREAD-1:0]       rs_busy;
    logic [NREAD-1:0]       rs_illegal;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*5-1:0]    wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   iss_en;
    logic [4:0]             iss_rd;
    logic                   flush;
    logic [5:0]             busy_count;
    logic [4:0]             dbg_sel;
    logic [XLEN-1:0]        dbg_data;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data,
        output iss_en, iss_rd, flush, dbg_sel,
        input  rs_data, rs_busy, rs_illegal,
        input  busy_count, dbg_data
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data,
        input  iss_en, iss_rd, flush, dbg_sel,
        output rs_data, rs_busy, rs_illegal,
        output busy_count, dbg_data
    );
endinterface

// File: rtl/cpu_regfile_mp.sv
// Multi-port integer register file with pending-write
// scoreboard for RAW hazard detection at issue.
module cpu_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1
) (
    input logic           clk,
    input logic           reset,
    cpu_regfile_mp_if.slave rf
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] wr_val [NREG];
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [5:0]      count;
    logic [5:0]      count_nxt;
    logic [4:0]      ra;
    logic            fwd;
    logic [XLEN-1:0] fwd_val;

    function automatic logic in_range(logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREG);
    endfunction

    // Per-register write decode; the highest write port wins.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREG; r++) wr_val[r] = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (rf.wr_en[j] && rf.wr_addr[5*j +: 5] == 5'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = rf.wr_data[XLEN*j +: XLEN];
                end
            end
        end
    end

    // Next busy vector (flush > issue > write-back) and its popcount.
    always_comb begin
        busy_nxt  = '0;
        count_nxt = '0;
        for (int r = 1; r < NREG; r++) begin
            if (rf.flush)
                busy_nxt[r] = 1'b0;
            else if (rf.iss_en && rf.iss_rd == 5'(r))
                busy_nxt[r] = 1'b1;
            else if (wr_hit[r])
                busy_nxt[r] = 1'b0;
            else
                busy_nxt[r] = busy[r];
            count_nxt = count_nxt + 6'(busy_nxt[r]);
        end
    end

    // Architectural state, busy bits and registered busy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            busy  <= '0;
            count <= '0;
        end else begin
            for (int r = 1; r < NREG; r++)
                if (wr_hit[r]) regs[r] <= wr_val[r];
            busy  <= busy_nxt;
            count <= count_nxt;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        rf.rs_data    = '0;
        rf.rs_busy    = '0;
        rf.rs_illegal = '0;
        ra            = '0;
        fwd           = 1'b0;
        fwd_val       = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra      = rf.rs_addr[5*k +: 5];
            fwd     = 1'b0;
            fwd_val = '0;
            for (int j = 0; j < NWRITE; j++) begin
                if (rf.wr_en[j] && rf.wr_addr[5*j +: 5] == ra) begin
                    fwd     = 1'b1;
                    fwd_val = rf.wr_data[XLEN*j +: XLEN];
                end
            end
            fwd = fwd && (BYPASS != 0) && in_range(ra);
            rf.rs_illegal[k] = int'(ra) >= NREG;
            if (in_range(ra)) begin
                rf.rs_data[XLEN*k +: XLEN] = fwd ? fwd_val : regs[ra[AW-1:0]];
                rf.rs_busy[k] = !fwd && busy[ra[AW-1:0]];
            end
        end
    end

    assign rf.dbg_data = in_range(rf.dbg_sel) ? regs[rf.dbg_sel[AW-1:0]] : '0;
    assign rf.busy_count = count;
endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Bench for cpu_regfile_mp: two configurations driven by one
// directed stimulus, checked against a register/busy array model.
module tb_cpu_regfile_mp;
    localparam int P_NREG [2] = '{32, 16};
    localparam int P_NW   [2] = '{2, 1};
    localparam int P_BYP  [2] = '{1, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  rs_addr = '0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        flush = 1'b0;
    logic [4:0]  dbg_sel = '0;
    bit          run = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [2][32];
    bit          bsy [2][32];
    int          cnt [2];

    always #5 clk = ~clk;

    cpu_regfile_mp_if #(.XLEN(32), .NREAD(2), .NWRITE(2)) ia ();
    cpu_regfile_mp_if #(.XLEN(32), .NREAD(2), .NWRITE(1)) ib ();

    assign ia.rs_addr = rs_addr;
    assign ia.wr_en   = wr_en;
    assign ia.wr_addr = wr_addr;
    assign ia.wr_data = wr_data;
    assign ia.iss_en  = iss_en;
    assign ia.iss_rd  = iss_rd;
    assign ia.flush   = flush;
    assign ia.dbg_sel = dbg_sel;
    assign ib.rs_addr = rs_addr;
    assign ib.wr_en   = wr_en[0];
    assign ib.wr_addr = wr_addr[4:0];
    assign ib.wr_data = wr_data[31:0];
    assign ib.iss_en  = iss_en;
    assign ib.iss_rd  = iss_rd;
    assign ib.flush   = flush;
    assign ib.dbg_sel = dbg_sel;

    cpu_regfile_mp #(
        .XLEN(32), .NREG(32), .NREAD(2), .NWRITE(2), .BYPASS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .rf(ia.slave)
    );

    cpu_regfile_mp #(
        .XLEN(32), .NREG(16), .NREAD(2), .NWRITE(1), .BYPASS(0)
    ) dut_b (
        .clk(clk), .reset(reset), .rf(ib.slave)
    );

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) begin
                mem[i][r] = '0;
                bsy[i][r] = 1'b0;
            end
            cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit w;
        int c;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            c = 0;
            for (int r = 1; r < P_NREG[i]; r++) begin
                w = 1'b0;
                for (int j = 0; j < P_NW[i]; j++) begin
                    if (wr_en[j] && wr_addr[5*j +: 5] == 5'(r)) begin
                        mem[i][r] = wr_data[32*j +: 32];
                        w = 1'b1;
                    end
                end
                if (flush) bsy[i][r] = 1'b0;
                else if (iss_en && iss_rd == 5'(r)) bsy[i][r] = 1'b1;
                else if (w) bsy[i][r] = 1'b0;
                c += int'(bsy[i][r]);
            end
            cnt[i] = c;
        end
    endtask

    function automatic bit legal(int i, logic [4:0] a);
        return a != 0 && int'(a) < P_NREG[i];
    endfunction

    function automatic bit fwd_hit(int i, logic [4:0] a);
        bit h = 1'b0;
        if (P_BYP[i] == 0 || !legal(i, a)) return 1'b0;
        for (int j = 0; j < P_NW[i]; j++)
            if (wr_en[j] && wr_addr[5*j +: 5] == a) h = 1'b1;
        return h;
    endfunction

    function automatic logic [31:0] e_data(int i, logic [4:0] a);
        logic [31:0] v;
        if (!legal(i, a)) return '0;
        v = mem[i][a];
        if (fwd_hit(i, a))
            for (int j = 0; j < P_NW[i]; j++)
                if (wr_en[j] && wr_addr[5*j +: 5] == a) v = wr_data[32*j +: 32];
        return v;
    endfunction

    function automatic logic e_busy(int i, logic [4:0] a);
        if (!legal(i, a) || fwd_hit(i, a)) return 1'b0;
        return bsy[i][a];
    endfunction

    function automatic logic [31:0] e_dbg(int i, logic [4:0] a);
        return legal(i, a) ? mem[i][a] : 32'h0;
    endfunction

    // Every cycle: all outputs of both configurations against the model.
    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("a.rs_data%0d", k), 64'(ia.rs_data[32*k +: 32]),
                      64'(e_data(0, rs_addr[5*k +: 5])));
                check($sformatf("a.rs_busy%0d", k), 64'(ia.rs_busy[k]),
                      64'(e_busy(0, rs_addr[5*k +: 5])));
                check($sformatf("a.rs_illegal%0d", k), 64'(ia.rs_illegal[k]), 64'(0));
                check($sformatf("b.rs_data%0d", k), 64'(ib.rs_data[32*k +: 32]),
                      64'(e_data(1, rs_addr[5*k +: 5])));
                check($sformatf("b.rs_busy%0d", k), 64'(ib.rs_busy[k]),
                      64'(e_busy(1, rs_addr[5*k +: 5])));
                check($sformatf("b.rs_illegal%0d", k), 64'(ib.rs_illegal[k]),
                      64'(rs_addr[5*k +: 5] >= 5'd16));
            end
            check("a.busy_count", 64'(ia.busy_count), 64'(cnt[0]));
            check("b.busy_count", 64'(ib.busy_count), 64'(cnt[1]));
            check("a.dbg_data", 64'(ia.dbg_data), 64'(e_dbg(0, dbg_sel)));
            check("b.dbg_data", 64'(ib.dbg_data), 64'(e_dbg(1, dbg_sel)));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_rd  = '0;
        flush   = 1'b0;
    endtask

    task automatic wr(int port, logic [4:0] a, logic [31:0] d);
        wr_en[port]            = 1'b1;
        wr_addr[5*port +: 5]   = a;
        wr_data[32*port +: 32] = d;
    endtask

    initial begin
        idle();
        #1;
        reset = 1'b1;
        model_reset();
        run = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // reset state across the full address space
        for (int a = 0; a < 32; a++) begin
            rs_addr = {5'(a), 5'(a)};
            dbg_sel = 5'(a);
            tick();
        end
        check("reset_count", 64'(ia.busy_count), 64'(0));

        // write x5, bypass versus committed-only read
        rs_addr = {5'd0, 5'd5};
        dbg_sel = 5'd5;
        wr(0, 5'd5, 32'hDEADBEEF);
        #1;
        check("a_byp_x5", 64'(ia.rs_data[31:0]), 64'hDEADBEEF);
        check("b_nobyp_x5", 64'(ib.rs_data[31:0]), 64'h0);
        check("a_dbg_pre", 64'(ia.dbg_data), 64'h0);
        tick();
        idle();
        #1;
        check("a_dbg_x5", 64'(ia.dbg_data), 64'hDEADBEEF);
        check("b_rd_x5", 64'(ib.rs_data[31:0]), 64'hDEADBEEF);
        tick();

        // issue x7, then write it back
        iss_en = 1'b1;
        iss_rd = 5'd7;
        tick();
        idle();
        rs_addr = {5'd0, 5'd7};
        #1;
        check("a_busy_x7", 64'(ia.rs_busy[0]), 64'h1);
        check("a_count1", 64'(ia.busy_count), 64'h1);
        wr(0, 5'd7, 32'h42);
        #1;
        check("a_fwd_nobusy", 64'(ia.rs_busy[0]), 64'h0);
        check("b_still_busy", 64'(ib.rs_busy[0]), 64'h1);
        tick();
        idle();
        #1;
        check("a_count0", 64'(ia.busy_count), 64'h0);
        check("a_x7", 64'(ia.rs_data[31:0]), 64'h42);

        // issue and write the same register in one cycle
        iss_en = 1'b1;
        iss_rd = 5'd9;
        wr(0, 5'd9, 32'h11);
        tick();
        idle();
        rs_addr = {5'd0, 5'd9};
        dbg_sel = 5'd9;
        #1;
        check("a_x9", 64'(ia.dbg_data), 64'h11);
        check("a_busy_x9", 64'(ia.rs_busy[0]), 64'h1);
        check("a_count_x9", 64'(ia.busy_count), 64'h1);

        // two write ports to x3; higher port wins
        rs_addr = {5'd3, 5'd0};
        wr(0, 5'd3, 32'h1);
        wr(1, 5'd3, 32'h2);
        #1;
        check("a_fwd_hi_port", 64'(ia.rs_data[63:32]), 64'h2);
        tick();
        idle();
        dbg_sel = 5'd3;
        #1;
        check("a_x3", 64'(ia.dbg_data), 64'h2);
        check("b_x3", 64'(ib.dbg_data), 64'h1);

        // x0 is hardwired
        wr(0, 5'd0, 32'hFF);
        rs_addr = {5'd0, 5'd0};
        tick();
        idle();
        dbg_sel = 5'd0;
        #1;
        check("a_x0", 64'(ia.rs_data[31:0]), 64'h0);

        // out-of-range register on the 16-entry file
        rs_addr = {5'd20, 5'd20};
        dbg_sel = 5'd20;
        #1;
        check("b_illegal", 64'(ib.rs_illegal), 64'h3);
        check("b_rd_x20", 64'(ib.rs_data), 64'h0);
        wr(0, 5'd20, 32'h55);
        tick();
        idle();
        dbg_sel = 5'd4;
        #1;
        check("b_x4_alias", 64'(ib.dbg_data), 64'h0);
        rs_addr = {5'd0, 5'd20};
        #1;
        check("a_x20", 64'(ia.rs_data[31:0]), 64'h55);

        // issue x1..x4 and x20, then flush with a competing issue
        for (int r = 1; r <= 4; r++) begin
            iss_en = 1'b1;
            iss_rd = 5'(r);
            tick();
        end
        iss_rd = 5'd20;
        tick();
        idle();
        #1;
        check("a_count6", 64'(ia.busy_count), 64'd6);
        check("b_count5", 64'(ib.busy_count), 64'd5);
        flush  = 1'b1;
        iss_en = 1'b1;
        iss_rd = 5'd5;
        wr(0, 5'd6, 32'h66);
        tick();
        idle();
        rs_addr = {5'd6, 5'd5};
        #1;
        check("a_flush_count", 64'(ia.busy_count), 64'd0);
        check("a_flush_iss", 64'(ia.rs_busy), 64'h0);
        check("a_flush_wr", 64'(ia.rs_data[63:32]), 64'h66);

        // higher registers on both files
        wr(0, 5'd31, 32'hA5A5_0031);
        wr(1, 5'd15, 32'h5A5A_0015);
        rs_addr = {5'd15, 5'd31};
        tick();
        wr(0, 5'd15, 32'h0000_B015);
        tick();
        idle();
        tick();

        // reset in the middle of a pending write
        wr(0, 5'd5, 32'h77);
        iss_en = 1'b1;
        iss_rd = 5'd6;
        tick();
        idle();
        wr(0, 5'd8, 32'h88);
        dbg_sel = 5'd5;
        rs_addr = {5'd8, 5'd6};
        #2;
        reset = 1'b1;
        idle();
        model_reset();
        #1;
        check("rst_dbg_x5", 64'(ia.dbg_data), 64'h0);
        check("rst_count", 64'(ia.busy_count), 64'h0);
        check("rst_busy", 64'(ia.rs_busy), 64'h0);
        tick();
        reset = 1'b0;
        tick();
        dbg_sel = 5'd8;
        #1;
        check("rst_lost_wr", 64'(ia.dbg_data), 64'h0);
        tick();

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
